// File: rtl/lightbike_pkg.sv
// Shared definitions for the light-bike round sequencer: FSM encodings,
// keyboard scan codes, bike count and small bit-counting helpers.
package lightbike_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_RUN       = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  localparam logic [7:0] KEY_START = 8'h29;  // space
  localparam logic [7:0] KEY_ABORT = 8'h76;  // Esc
  localparam int         NUM_BIKES = 4;

  localparam logic [3:0] MASK_TWO  = 4'b0011;
  localparam logic [3:0] MASK_FOUR = 4'b1111;

  // Number of set bits in a 4-bit bike vector.
  function automatic logic [2:0] bike_count(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_BIKES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // 1-based number of the lowest set bike, 0 when no bit is set.
  function automatic logic [2:0] first_bike(input logic [3:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_BIKES - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sec_tick.sv
// Seconds divider: counts enabled cycles and pulses tick on the last cycle
// of every CYCLES_PER_SEC window. Dropping enable restarts the count at 0.
module sec_tick #(
  parameter int CYCLES_PER_SEC = 10000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_SEC - 1);

  logic [CW-1:0] cnt_q;

  // Cycle counter held at zero while disabled, wraps after LAST.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer for the light-bike game: waits for the start key, wipes the
// map, counts down, runs the round until at most one bike survives, then
// records the winner and its score. Esc returns to IDLE from any other state.
module round_sequencer
  import lightbike_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 10000000,
  parameter int COUNT_FROM     = 3,
  parameter int CLEAR_CYCLES   = 4096,
  parameter int SCORE_W        = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_pressed,
  input  logic [7:0]             key_data,
  input  logic                   four_player_mode,
  input  logic [3:0]             crash,
  output logic                   run_en,
  output logic                   map_clear,
  output logic [3:0]             countdown,
  output logic [2:0]             state,
  output logic [2:0]             winner,
  output logic [4*SCORE_W-1:0]   scores
);

  localparam int CLW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLW-1:0]     CLEAR_LAST = CLW'(CLEAR_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [3:0]         COUNT_INIT = 4'(COUNT_FROM);

  state_t               state_q, state_d;
  logic [CLW-1:0]       clear_cnt_q, clear_cnt_d;
  logic [3:0]           mask_q, mask_d;
  logic [3:0]           countdown_q, countdown_d;
  logic [2:0]           winner_q, winner_d;
  logic [4*SCORE_W-1:0] scores_q, scores_d;
  logic                 run_en_q, run_en_d;
  logic                 map_clear_q, map_clear_d;

  logic       start_key;
  logic       abort_key;
  logic       tick;
  logic [3:0] alive;

  assign start_key = key_pressed && (key_data == KEY_START);
  assign abort_key = key_pressed && (key_data == KEY_ABORT);
  // Bikes outside the latched mask never count as alive, whatever crash says.
  assign alive     = ~crash & mask_q;

  // The divider only runs in COUNTDOWN, so each entry starts a fresh second.
  sec_tick #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_sec_tick (
    .clock (clock),
    .reset (reset),
    .enable(state_q == ST_COUNTDOWN),
    .tick  (tick)
  );

  // State register plus every registered output; reset overrides all inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clear_cnt_q <= '0;
      mask_q      <= MASK_TWO;
      countdown_q <= '0;
      winner_q    <= '0;
      scores_q    <= '0;
      run_en_q    <= 1'b0;
      map_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      mask_q      <= mask_d;
      countdown_q <= countdown_d;
      winner_q    <= winner_d;
      scores_q    <= scores_d;
      run_en_q    <= run_en_d;
      map_clear_q <= map_clear_d;
    end
  end

  // Next-state and next-output logic; outputs follow the next state so they
  // change on the same edge as the state register.
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    mask_d      = mask_q;
    winner_d    = winner_q;
    scores_d    = scores_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_key) begin
          state_d     = ST_CLEAR;
          clear_cnt_d = '0;
          winner_d    = '0;
          mask_d      = four_player_mode ? MASK_FOUR : MASK_TWO;
        end
      end
      ST_CLEAR: begin
        if (clear_cnt_q == CLEAR_LAST) begin
          state_d     = ST_COUNTDOWN;
          clear_cnt_d = '0;
        end else begin
          clear_cnt_d = clear_cnt_q + 1'b1;
        end
      end
      ST_COUNTDOWN: begin
        if (tick && (countdown_q == 4'd1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bike_count(alive) <= 3'd1) begin
          state_d  = ST_OVER;
          winner_d = first_bike(alive);
          for (int b = 0; b < NUM_BIKES; b++) begin
            if ((winner_d == 3'(b + 1)) &&
                (scores_q[b*SCORE_W +: SCORE_W] != SCORE_MAX)) begin
              scores_d[b*SCORE_W +: SCORE_W] =
                scores_q[b*SCORE_W +: SCORE_W] + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort beats everything else, including a game-over seen this cycle.
    if (abort_key && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      clear_cnt_d = '0;
      mask_d      = mask_q;
      winner_d    = winner_q;
      scores_d    = scores_q;
    end

    if (state_d != ST_COUNTDOWN) begin
      countdown_d = '0;
    end else if (state_q != ST_COUNTDOWN) begin
      countdown_d = COUNT_INIT;
    end else if (tick) begin
      countdown_d = countdown_q - 4'd1;
    end else begin
      countdown_d = countdown_q;
    end

    run_en_d    = (state_d == ST_RUN);
    map_clear_d = (state_d == ST_CLEAR);
  end

  assign state     = state_q;
  assign run_en    = run_en_q;
  assign map_clear = map_clear_q;
  assign countdown = countdown_q;
  assign winner    = winner_q;
  assign scores    = scores_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a short second (10 cycles), a
// 3-2-1 countdown and an 8-cycle map clear.
module tb_round_sequencer;

  localparam int SW = 4;
  localparam logic [7:0] K_START = 8'h29;
  localparam logic [7:0] K_ABORT = 8'h76;
  localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_CD = 3'd2,
                         S_RUN = 3'd3, S_OVER = 3'd4;

  // clock / reset block
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic            key_pressed;
  logic [7:0]      key_data;
  logic            four_player_mode;
  logic [3:0]      crash;
  logic            run_en;
  logic            map_clear;
  logic [3:0]      countdown;
  logic [2:0]      state;
  logic [2:0]      winner;
  logic [4*SW-1:0] scores;

  int n_vec = 0;
  int n_err = 0;

  round_sequencer #(
    .CYCLES_PER_SEC(10),
    .COUNT_FROM    (3),
    .CLEAR_CYCLES  (8),
    .SCORE_W       (SW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .key_pressed     (key_pressed),
    .key_data        (key_data),
    .four_player_mode(four_player_mode),
    .crash           (crash),
    .run_en          (run_en),
    .map_clear       (map_clear),
    .countdown       (countdown),
    .state           (state),
    .winner          (winner),
    .scores          (scores)
  );

  // Advance n clock edges; inputs and samples sit 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One-cycle key strobe.
  task automatic press(input logic [7:0] code);
    key_pressed = 1'b1;
    key_data    = code;
    step(1);
    key_pressed = 1'b0;
    key_data    = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start key, then 8 clear cycles and 30 countdown cycles land in RUN.
  task automatic start_round(input logic fp);
    four_player_mode = fp;
    press(K_START);
    step(38);
    chk("round_in_run", {29'd0, state}, {29'd0, S_RUN});
  endtask

  initial begin
    reset = 1'b1; key_pressed = 1'b0; key_data = 8'h00;
    four_player_mode = 1'b0; crash = 4'b0000;
    step(3);
    chk("rst_state", {29'd0, state}, {29'd0, S_IDLE});
    chk("rst_run_en", {31'd0, run_en}, 32'd0);
    chk("rst_map_clear", {31'd0, map_clear}, 32'd0);
    chk("rst_countdown", {28'd0, countdown}, 32'd0);
    chk("rst_winner", {29'd0, winner}, 32'd0);
    chk("rst_scores", {16'd0, scores}, 32'd0);
    reset = 1'b0;
    step(1);

    // unrelated key in IDLE is ignored
    press(8'h12);
    chk("idle_other_key", {29'd0, state}, {29'd0, S_IDLE});

    // full start sequence: 8 clear cycles, then 3,2,1 for 10 cycles each
    press(K_START);
    for (int i = 0; i < 8; i++) begin
      chk("clear_state", {29'd0, state}, {29'd0, S_CLEAR});
      chk("clear_map_clear", {31'd0, map_clear}, 32'd1);
      chk("clear_run_en", {31'd0, run_en}, 32'd0);
      if (i == 3) press(K_START);  // start key ignored mid-clear
      else step(1);
    end
    for (int d = 3; d >= 1; d--) begin
      for (int j = 0; j < 10; j++) begin
        chk("cd_state", {29'd0, state}, {29'd0, S_CD});
        chk("cd_value", {28'd0, countdown}, 32'(d));
        chk("cd_map_clear", {31'd0, map_clear}, 32'd0);
        step(1);
      end
    end
    chk("run_state", {29'd0, state}, {29'd0, S_RUN});
    chk("run_en_high", {31'd0, run_en}, 32'd1);
    chk("run_countdown0", {28'd0, countdown}, 32'd0);

    // 2-player: bike three outside the mask, start key in RUN ignored
    crash = 4'b0100;
    step(1);
    chk("masked_crash", {29'd0, state}, {29'd0, S_RUN});
    press(K_START);
    chk("start_in_run", {31'd0, run_en}, 32'd1);
    crash = 4'b0101;
    step(1);
    chk("over_state", {29'd0, state}, {29'd0, S_OVER});
    chk("over_run_en", {31'd0, run_en}, 32'd0);
    chk("over_winner2", {29'd0, winner}, 32'd2);
    chk("over_scores", {16'd0, scores}, 32'h0010);
    step(2);
    chk("winner_held", {29'd0, winner}, 32'd2);
    crash = 4'b0000;

    // 4-player round; mode drop after CLEAR entry must not shrink the mask
    four_player_mode = 1'b1;
    press(K_START);
    chk("clear_winner0", {29'd0, winner}, 32'd0);
    four_player_mode = 1'b0;
    step(38);
    chk("fp_run", {29'd0, state}, {29'd0, S_RUN});
    crash = 4'b0011;
    step(1);
    chk("fp_two_alive", {29'd0, state}, {29'd0, S_RUN});
    crash = 4'b1111;
    step(1);
    chk("draw_state", {29'd0, state}, {29'd0, S_OVER});
    chk("draw_winner", {29'd0, winner}, 32'd0);
    chk("draw_scores", {16'd0, scores}, 32'h0010);
    crash = 4'b0000;

    // bike one wins 16 times, score saturates at 15
    for (int r = 1; r <= 16; r++) begin
      start_round(1'b0);
      crash = 4'b0010;
      step(1);
      chk("sat_winner", {29'd0, winner}, 32'd1);
      chk("sat_score1", {28'd0, scores[3:0]}, (r > 15) ? 32'd15 : 32'(r));
      crash = 4'b0000;
    end
    chk("sat_scores", {16'd0, scores}, 32'h001F);

    // Esc during countdown at 2
    press(K_START);
    step(18);
    chk("esc_cd2", {28'd0, countdown}, 32'd2);
    press(K_ABORT);
    chk("esc_state", {29'd0, state}, {29'd0, S_IDLE});
    chk("esc_countdown", {28'd0, countdown}, 32'd0);
    chk("esc_map_clear", {31'd0, map_clear}, 32'd0);
    chk("esc_run_en", {31'd0, run_en}, 32'd0);
    chk("esc_scores", {16'd0, scores}, 32'h001F);

    // Esc coincident with final crash: abort wins, no score
    start_round(1'b0);
    crash = 4'b0001; key_pressed = 1'b1; key_data = K_ABORT;
    step(1);
    key_pressed = 1'b0; key_data = 8'h00;
    chk("esc_crash_state", {29'd0, state}, {29'd0, S_IDLE});
    chk("esc_crash_run_en", {31'd0, run_en}, 32'd0);
    chk("esc_crash_scores", {16'd0, scores}, 32'h001F);
    crash = 4'b0000;

    // Esc in OVER keeps the winner
    start_round(1'b0);
    crash = 4'b0001;
    step(1);
    chk("win2_winner", {29'd0, winner}, 32'd2);
    chk("win2_scores", {16'd0, scores}, 32'h002F);
    crash = 4'b0000;
    press(K_ABORT);
    chk("over_esc_state", {29'd0, state}, {29'd0, S_IDLE});
    chk("over_esc_winner", {29'd0, winner}, 32'd2);

    // reset mid-RUN beats key and crash inputs
    start_round(1'b1);
    step(5);
    reset = 1'b1; key_pressed = 1'b1; key_data = K_START; crash = 4'b1110;
    step(1);
    chk("mid_rst_state", {29'd0, state}, {29'd0, S_IDLE});
    chk("mid_rst_run_en", {31'd0, run_en}, 32'd0);
    chk("mid_rst_map_clear", {31'd0, map_clear}, 32'd0);
    chk("mid_rst_countdown", {28'd0, countdown}, 32'd0);
    chk("mid_rst_winner", {29'd0, winner}, 32'd0);
    chk("mid_rst_scores", {16'd0, scores}, 32'd0);
    reset = 1'b0; key_pressed = 1'b0; key_data = 8'h00; crash = 4'b0000;
    step(1);
    chk("post_rst_idle", {29'd0, state}, {29'd0, S_IDLE});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter CYCLES_PER_SEC, default 10000000, clock cycles per countdown second (10 MHz core clock).
REQ-002 Parameter COUNT_FROM, default 3, first countdown value shown; legal 1..15.
REQ-003 Parameter CLEAR_CYCLES, default 4096, cycles map_clear is held to wipe trails.
REQ-004 Parameter SCORE_W, default 4, width of each per-bike win counter.
REQ-005 clock  in  1  single core clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 key_pressed  in  1  one-cycle strobe, key_data valid.
REQ-008 key_data  in  8  PS/2 scan code.
REQ-009 four_player_mode  in  1  level; selects 4 vs 2 active bikes.
REQ-010 crash  in  4  per-bike crash flags, bit0 = bike one; level, sticky until map clear.
REQ-011 run_en  out  1  enables bike movement (drives processor master switch).
REQ-012 map_clear  out  1  high while trails/positions are being reset.
REQ-013 countdown  out  4  current countdown digit, 0 outside COUNTDOWN.
REQ-014 state  out  3  current FSM state encoding.
REQ-015 winner  out  3  0 = none/draw, 1..4 = winning bike.
REQ-016 scores  out  4*SCORE_W  win counters, bike one in LSBs.

Function
REQ-017 States SHALL be IDLE, CLEAR, COUNTDOWN, RUN, OVER; all outputs registered.
REQ-018 Start key = 8'h29 (space); abort key = 8'h76 (Esc); all other codes ignored.
REQ-019 IDLE: start key -> CLEAR next cycle; run_en=0.
REQ-020 CLEAR: map_clear=1 for exactly CLEAR_CYCLES cycles, winner cleared to 0, active mask latched (4'b1111 if four_player_mode else 4'b0011), then -> COUNTDOWN.
REQ-021 COUNTDOWN: countdown loads COUNT_FROM on entry, decrements on each second tick (CYCLES_PER_SEC cycles from entry); tick at countdown==1 -> RUN with countdown=0.
REQ-022 RUN: run_en=1; alive = ~crash & mask; when popcount(alive) <= 1 -> OVER, run_en low the following cycle (1-cycle detect latency).
REQ-023 Entering OVER: exactly one alive -> winner = its index+1 and its score +1, saturating at 2^SCORE_W-1; zero alive (simultaneous crash) -> winner=0, no score change.
REQ-024 OVER: run_en=0, winner held; start key -> CLEAR.
REQ-025 Start key in CLEAR, COUNTDOWN or RUN SHALL be ignored.
REQ-026 Abort key in any state except IDLE -> IDLE next cycle, run_en=0, map_clear=0, countdown=0; scores and winner kept.
REQ-027 Abort and game-over detection in same cycle: abort wins, no score update.
REQ-028 four_player_mode changes after CLEAR entry SHALL not affect the current round.
REQ-029 crash bits outside the mask SHALL be ignored.
REQ-030 Second-tick counter SHALL restart on every COUNTDOWN entry; no wrap beyond CYCLES_PER_SEC-1.

Reset
REQ-031 reset SHALL force IDLE, run_en=0, map_clear=0, countdown=0, winner=0, scores=0, tick and clear counters=0, mask=4'b0011.
REQ-032 reset SHALL take priority over all key and crash inputs in the same cycle.

Structure
REQ-033 State encodings, start/abort scan codes and bike count SHALL live in shared package lightbike_pkg.
REQ-034 One sub-module, sec_tick (enable-gated, restartable CYCLES_PER_SEC divider), SHALL generate the second tick.

Verification (CYCLES_PER_SEC=10, COUNT_FROM=3, CLEAR_CYCLES=8)
REQ-035 Reset, key 8'h29 -> map_clear high 8 cycles, countdown 3,2,1 each 10 cycles, run_en=1 at cycle 39 after CLEAR entry.
REQ-036 2-player RUN, crash=4'b0001 -> OVER, winner=2, scores[7:4]=1, run_en=0 next cycle; crash=4'b0100 alone has no effect.
REQ-037 4-player RUN, crash 4'b0000->4'b1111 in one cycle -> winner=0, scores unchanged.
REQ-038 Win bike one 16 times (SCORE_W=4) -> scores[3:0] saturates at 15.
REQ-039 Esc during COUNTDOWN at countdown=2 -> IDLE next cycle, countdown=0; Esc coincident with final crash in RUN -> IDLE, no score change.
REQ-040 reset asserted mid-RUN -> next cycle IDLE, all outputs zero.
